alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Optional grant statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             req_valid_0_i,
   output logic             req_ready_0_o,
   input  logic [31:0]      req_data1_0_i,
   input  logic [31:0]      req_data2_0_i,
   input  logic [3:0]       req_op_0_i,
   output logic             rsp_valid_0_o,
   input  logic             rsp_ready_0_i,
   output logic [31:0]      rsp_result_0_o,

   input  logic             req_valid_1_i,
   output logic             req_ready_1_o,
   input  logic [31:0]      req_data1_1_i,
   input  logic [31:0]      req_data2_1_i,
   input  logic [3:0]       req_op_1_i,
   output logic             rsp_valid_1_o,
   input  logic             rsp_ready_1_i,
   output logic [31:0]      rsp_result_1_o,

   output logic [31:0]      alu_data1_o,
   output logic [31:0]      alu_data2_o,
   output logic [3:0]       alu_op_o,
   input  logic [31:0]      alu_result_i,

   output logic [CNT_W-1:0] grant_cnt_0_o,
   output logic [CNT_W-1:0] grant_cnt_1_o
);

   localparam int unsigned GntW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {StEmpty, StFull} slot_state_e;

   logic [1:0]      w_req_valid;
   logic [1:0]      w_rsp_ready;
   logic [31:0]     w_data1 [2];
   logic [31:0]     w_data2 [2];
   logic [3:0]      w_op    [2];
   logic [1:0]      w_slot_free;
   logic [1:0]      w_elig;
   logic [1:0]      w_gnt;
   logic            w_last_is_1;

   slot_state_e     r_state  [2];
   logic [31:0]     r_result [2];
   logic [GntW-1:0] r_last_gnt;

   assign w_req_valid = {req_valid_1_i, req_valid_0_i};
   assign w_rsp_ready = {rsp_ready_1_i, rsp_ready_0_i};
   assign w_data1[0]  = req_data1_0_i;
   assign w_data1[1]  = req_data1_1_i;
   assign w_data2[0]  = req_data2_0_i;
   assign w_data2[1]  = req_data2_1_i;
   assign w_op[0]     = req_op_0_i;
   assign w_op[1]     = req_op_1_i;

   // A full slot can be refilled in the same cycle it is drained.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         w_slot_free[k] = (r_state[k] == StEmpty) || w_rsp_ready[k];
         w_elig[k]      = w_req_valid[k] && w_slot_free[k] && !rst_i;
      end
   end

   assign w_last_is_1 = (r_last_gnt == GntW'(1));

   // Under contention the port that did not win most recently takes the grant.
   assign w_gnt[0] = w_elig[0] && (!w_elig[1] || w_last_is_1);
   assign w_gnt[1] = w_elig[1] && (!w_elig[0] || !w_last_is_1);

   assign req_ready_0_o = w_gnt[0];
   assign req_ready_1_o = w_gnt[1];

   always_comb begin
      alu_data1_o = 32'd0;
      alu_data2_o = 32'd0;
      alu_op_o    = 4'd0;
      if (w_gnt[0]) begin
         alu_data1_o = w_data1[0];
         alu_data2_o = w_data2[0];
         alu_op_o    = w_op[0];
      end else if (w_gnt[1]) begin
         alu_data1_o = w_data1[1];
         alu_data2_o = w_data2[1];
         alu_op_o    = w_op[1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last_gnt <= GntW'(1);
         for (int k = 0; k < 2; k++) begin
            r_state[k]  <= StEmpty;
            r_result[k] <= 32'd0;
         end
      end else begin
         if (|w_gnt) begin
            r_last_gnt <= GntW'(w_gnt[1]);
         end
         for (int k = 0; k < 2; k++) begin
            case (r_state[k])
               StEmpty: begin
                  if (w_gnt[k]) begin
                     r_state[k]  <= StFull;
                     r_result[k] <= alu_result_i;
                  end
               end
               StFull: begin
                  if (w_gnt[k]) begin
                     r_result[k] <= alu_result_i;
                  end else if (w_rsp_ready[k]) begin
                     r_state[k] <= StEmpty;
                  end
               end
               default: r_state[k] <= StEmpty;
            endcase
         end
      end
   end

   assign rsp_valid_0_o  = (r_state[0] == StFull);
   assign rsp_valid_1_o  = (r_state[1] == StFull);
   assign rsp_result_0_o = r_result[0];
   assign rsp_result_1_o = r_result[1];

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] r_cnt [2];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (w_gnt[k]) begin
               r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
         end
      end
   end

   assign grant_cnt_0_o = r_cnt[0];
   assign grant_cnt_1_o = r_cnt[1];
`else
   assign grant_cnt_0_o = '0;
   assign grant_cnt_1_o = '0;
`endif

   a_gnt_onehot: assert property (@(posedge clk_i) !(w_gnt[0] && w_gnt[1]));
   a_no_gnt_in_reset: assert property (@(posedge clk_i) rst_i |-> (w_gnt == 2'b00));

endmodule
